// File: rtl/cmac_pkg.sv
// Shared types and helpers for the pipelined complex multiply-accumulate unit.
package cmac_pkg;

  // Register stages from operand capture to the accumulator update.
  localparam int CMAC_LAT = 4;

  // Accumulator width: full-precision complex product plus guard bits.
  function automatic int acc_w(input int n, input int g);
    return 2 * n + 1 + g;
  endfunction

  // Frame tag carried alongside every sample.
  typedef struct packed {
    logic vld;
    logic last;
  } tag_t;

  // Tag plus the per-sample conjugate bit, needed until the sum/difference stage.
  typedef struct packed {
    tag_t tag;
    logic conj;
  } ctl_t;

endpackage

// File: rtl/cmac_sat_acc.sv
// One-component saturating accumulator: loads on the first sample of a frame,
// clamps on overflow with a sticky flag, and publishes the sum on the last sample.
module cmac_sat_acc #(
  parameter int IN_W  = 17,
  parameter int ACC_W = 21
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    vld,
  input  logic                    last,
  input  logic signed [IN_W-1:0]  din,
  output logic signed [ACC_W-1:0] out_val,
  output logic                    out_ovf
);

  localparam int SUM_W = ACC_W + 1;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] out_val_q, out_val_d;
  logic signed [ACC_W-1:0] base, sat;
  logic signed [SUM_W-1:0] sum;
  logic                    started_q, started_d;
  logic                    sticky_q, sticky_d;
  logic                    out_ovf_q, out_ovf_d;
  logic                    ovf;

  assign out_val = out_val_q;
  assign out_ovf = out_ovf_q;

  // Add the sample to the running sum (or to zero when a frame starts) and clamp to the true sign.
  always_comb begin
    base = started_q ? acc_q : '0;
    sum  = SUM_W'(base) + SUM_W'(din);
    ovf  = sum[SUM_W-1] ^ sum[SUM_W-2];
    sat  = sum[ACC_W-1:0];
    if (ovf) begin
      sat = sum[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Frame bookkeeping: keep accumulating mid-frame, publish and clear on the last sample.
  always_comb begin
    acc_d     = acc_q;
    started_d = started_q;
    sticky_d  = sticky_q;
    out_val_d = out_val_q;
    out_ovf_d = out_ovf_q;
    if (en && vld) begin
      if (last) begin
        out_val_d = sat;
        out_ovf_d = sticky_q | ovf;
        acc_d     = '0;
        started_d = 1'b0;
        sticky_d  = 1'b0;
      end else begin
        acc_d     = sat;
        started_d = 1'b1;
        sticky_d  = sticky_q | ovf;
      end
    end
  end

  // Accumulator, frame state and published result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      started_q <= 1'b0;
      sticky_q  <= 1'b0;
      out_val_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      started_q <= started_d;
      sticky_q  <= sticky_d;
      out_val_q <= out_val_d;
      out_ovf_q <= out_ovf_d;
    end
  end

endmodule

// File: rtl/cmac_pipe.sv
// Pipelined complex multiply-accumulate: capture, four products, sum/difference
// (with optional conj(b)), then a frame accumulator per component.
module cmac_pipe
  import cmac_pkg::*;
#(
  parameter int N = 8,
  parameter int G = 4,
  localparam int ACC_W = acc_w(N, G)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic                    conj_b,
  input  logic signed [N-1:0]     a_r,
  input  logic signed [N-1:0]     a_i,
  input  logic signed [N-1:0]     b_r,
  input  logic signed [N-1:0]     b_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_r,
  output logic signed [ACC_W-1:0] out_i,
  output logic                    out_ovf
);

  localparam int PW = 2 * N;
  localparam int SW = 2 * N + 1;

  typedef struct packed {
    logic signed [SW-1:0] re;
    logic signed [SW-1:0] im;
  } cplx_t;

  logic                 stall;
  ctl_t                 s1_ctl_q, s1_ctl_d, s2_ctl_q, s2_ctl_d;
  tag_t                 s3_tag_q, s3_tag_d, s4_tag_q, s4_tag_d;
  logic signed [N-1:0]  s1_ar_q, s1_ar_d, s1_ai_q, s1_ai_d;
  logic signed [N-1:0]  s1_br_q, s1_br_d, s1_bi_q, s1_bi_d;
  logic signed [PW-1:0] s2_rr_q, s2_rr_d, s2_ii_q, s2_ii_d;
  logic signed [PW-1:0] s2_ri_q, s2_ri_d, s2_ir_q, s2_ir_d;
  cplx_t                s3_q, s3_d, s4_q, s4_d;
  logic                 out_valid_q, out_valid_d;
  logic                 ovf_r, ovf_i;

  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = out_valid_q;
  assign out_ovf   = ovf_r | ovf_i;

  // Stage advance; every stage holds while the output is stalled.
  always_comb begin
    s1_ctl_d = s1_ctl_q;
    s1_ar_d  = s1_ar_q;
    s1_ai_d  = s1_ai_q;
    s1_br_d  = s1_br_q;
    s1_bi_d  = s1_bi_q;
    s2_ctl_d = s2_ctl_q;
    s2_rr_d  = s2_rr_q;
    s2_ii_d  = s2_ii_q;
    s2_ri_d  = s2_ri_q;
    s2_ir_d  = s2_ir_q;
    s3_tag_d = s3_tag_q;
    s3_d     = s3_q;
    s4_tag_d = s4_tag_q;
    s4_d     = s4_q;
    if (!stall) begin
      s1_ctl_d.tag.vld  = in_valid;
      s1_ctl_d.tag.last = in_valid & in_last;
      s1_ctl_d.conj     = conj_b;
      s1_ar_d           = a_r;
      s1_ai_d           = a_i;
      s1_br_d           = b_r;
      s1_bi_d           = b_i;
      s2_ctl_d          = s1_ctl_q;
      s2_rr_d           = PW'(s1_ar_q) * PW'(s1_br_q);
      s2_ii_d           = PW'(s1_ai_q) * PW'(s1_bi_q);
      s2_ri_d           = PW'(s1_ar_q) * PW'(s1_bi_q);
      s2_ir_d           = PW'(s1_ai_q) * PW'(s1_br_q);
      // conj(b) swaps add/subtract here instead of negating b_i, so b_i = -2^(N-1) stays exact.
      s3_tag_d          = s2_ctl_q.tag;
      s3_d.re = s2_ctl_q.conj ? SW'(s2_rr_q) + SW'(s2_ii_q) : SW'(s2_rr_q) - SW'(s2_ii_q);
      s3_d.im = s2_ctl_q.conj ? SW'(s2_ir_q) - SW'(s2_ri_q) : SW'(s2_ri_q) + SW'(s2_ir_q);
      s4_tag_d          = s3_tag_q;
      s4_d              = s3_q;
    end
  end

  // Result valid: cleared on acceptance, set when a frame-closing sample is accumulated.
  always_comb begin
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (!stall && s4_tag_q.vld && s4_tag_q.last) out_valid_d = 1'b1;
  end

  // Pipeline stage registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_ctl_q    <= '0;
      s1_ar_q     <= '0;
      s1_ai_q     <= '0;
      s1_br_q     <= '0;
      s1_bi_q     <= '0;
      s2_ctl_q    <= '0;
      s2_rr_q     <= '0;
      s2_ii_q     <= '0;
      s2_ri_q     <= '0;
      s2_ir_q     <= '0;
      s3_tag_q    <= '0;
      s3_q        <= '0;
      s4_tag_q    <= '0;
      s4_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_ctl_q    <= s1_ctl_d;
      s1_ar_q     <= s1_ar_d;
      s1_ai_q     <= s1_ai_d;
      s1_br_q     <= s1_br_d;
      s1_bi_q     <= s1_bi_d;
      s2_ctl_q    <= s2_ctl_d;
      s2_rr_q     <= s2_rr_d;
      s2_ii_q     <= s2_ii_d;
      s2_ri_q     <= s2_ri_d;
      s2_ir_q     <= s2_ir_d;
      s3_tag_q    <= s3_tag_d;
      s3_q        <= s3_d;
      s4_tag_q    <= s4_tag_d;
      s4_q        <= s4_d;
      out_valid_q <= out_valid_d;
    end
  end

  cmac_sat_acc #(.IN_W(SW), .ACC_W(ACC_W)) u_acc_r (
    .clk     (clk),
    .reset   (reset),
    .en      (~stall),
    .vld     (s4_tag_q.vld),
    .last    (s4_tag_q.last),
    .din     (s4_q.re),
    .out_val (out_r),
    .out_ovf (ovf_r)
  );

  cmac_sat_acc #(.IN_W(SW), .ACC_W(ACC_W)) u_acc_i (
    .clk     (clk),
    .reset   (reset),
    .en      (~stall),
    .vld     (s4_tag_q.vld),
    .last    (s4_tag_q.last),
    .din     (s4_q.im),
    .out_val (out_i),
    .out_ovf (ovf_i)
  );

endmodule

// File: tb/tb_cmac_pipe.sv
// Scoreboard bench for cmac_pipe (N=8, G=4): a saturating integer model pushes
// the expected frame result at acceptance; results are popped as the DUT emits them.
module tb_cmac_pipe;
  import cmac_pkg::*;

  localparam int N     = 8;
  localparam int G     = 4;
  localparam int ACC_W = 2 * N + 1 + G;
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));

  typedef struct {
    longint r;
    longint i;
    bit     ovf;
  } exp_t;

  logic                    clk;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_last;
  logic                    conj_b;
  logic signed [N-1:0]     a_r, a_i, b_r, b_i;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_r, out_i;
  logic                    out_ovf;

  int     checks = 0;
  int     errors = 0;
  exp_t   sb[$];
  longint m_r = 0;
  longint m_i = 0;
  bit     m_ovf = 0;

  cmac_pipe #(.N(N), .G(G)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .conj_b    (conj_b),
    .a_r       (a_r),
    .a_i       (a_i),
    .b_r       (b_r),
    .b_i       (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_accept(input int ar, input int ai, input int br, input int bi,
                                       input bit cj, input bit lst);
    longint pr, pi;
    if (cj) begin
      pr = longint'(ar * br + ai * bi);
      pi = longint'(ai * br - ar * bi);
    end else begin
      pr = longint'(ar * br - ai * bi);
      pi = longint'(ar * bi + ai * br);
    end
    m_r = m_r + pr;
    if (m_r > ACC_MAX) begin m_r = ACC_MAX; m_ovf = 1; end
    else if (m_r < ACC_MIN) begin m_r = ACC_MIN; m_ovf = 1; end
    m_i = m_i + pi;
    if (m_i > ACC_MAX) begin m_i = ACC_MAX; m_ovf = 1; end
    else if (m_i < ACC_MIN) begin m_i = ACC_MIN; m_ovf = 1; end
    if (lst) begin
      sb.push_back('{r: m_r, i: m_i, ovf: m_ovf});
      m_r = 0;
      m_i = 0;
      m_ovf = 0;
    end
  endfunction

  // Present one operand pair and hold it until accepted; called just after a rising edge.
  task automatic send(input int ar, input int ai, input int br, input int bi,
                      input bit cj, input bit lst);
    bit done = 0;
    int t = 0;
    in_valid = 1'b1;
    a_r = N'(ar);
    a_i = N'(ai);
    b_r = N'(br);
    b_i = N'(bi);
    conj_b = cj;
    in_last = lst;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
      if (done) model_accept(ar, ai, br, bi, cj, lst);
      else begin
        t++;
        if (t > 200) begin
          checks++;
          errors++;
          $display("FAIL send_timeout in_ready=%0b expected 1 within 200 cycles", in_ready);
          done = 1;
        end
      end
    end
  endtask

  // Take n results (out_ready must already be 1) and compare each against the scoreboard head.
  task automatic collect(input int n, input string name);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      int t = 0;
      @(negedge clk);
      while (!out_valid && t < 400) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (!out_valid) begin
        errors++;
        $display("FAIL %s[%0d] out_valid=0 expected 1 within 400 cycles", name, k);
        return;
      end
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s[%0d] unexpected result %0d,%0d expected no result", name, k,
                 out_r, out_i);
      end else begin
        e = sb.pop_front();
        if (longint'(out_r) !== e.r || longint'(out_i) !== e.i || out_ovf !== e.ovf) begin
          errors++;
          $display("FAIL %s[%0d] out=%0d,%0d ovf=%0b expected %0d,%0d ovf=%0b", name, k,
                   out_r, out_i, out_ovf, e.r, e.i, e.ovf);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_last = 1'b1;
    a_r = 8'sd5; a_i = 8'sd5; b_r = 8'sd5; b_i = 8'sd5;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_r !== '0 || out_i !== '0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs valid=%0b out=%0d,%0d ovf=%0b expected 0,0,0,0",
               out_valid, out_r, out_i, out_ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready in_ready=%0b expected 1", in_ready);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    for (int m = 0; m < 2; m++) begin
      send(1, 2, 3, 4, bit'(m), 1'b1);
      in_valid = 1'b0;
      for (int c = 1; c <= CMAC_LAT; c++) begin
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== (c == CMAC_LAT)) begin
          errors++;
          $display("FAIL single_latency[%0d] cycle %0d out_valid=%0b expected %0b", m, c,
                   out_valid, c == CMAC_LAT);
        end
      end
      collect(1, m == 0 ? "single_normal" : "single_conj");
    end
  endtask

  task automatic test_back_to_back();
    fork
      begin
        send(1, 2, 3, 4, 1'b0, 1'b0);
        send(2, 3, 4, 5, 1'b0, 1'b1);
        send(1, 0, 1, 0, 1'b0, 1'b1);
        in_valid = 1'b0;
      end
      collect(2, "back_to_back");
    join
  endtask

  task automatic test_saturation();
    fork
      begin
        send(-128, -128, -128, -128, 1'b0, 1'b1);
        for (int k = 0; k < 31; k++) send(-128, -128, -128, -128, 1'b0, k == 30);
        for (int k = 0; k < 32; k++) send(-128, -128, -128, -128, 1'b0, k == 31);
        for (int k = 0; k < 32; k++) send(-128, -128, -128, -128, 1'b0, 1'b0);
        send(-128, -128, 127, 127, 1'b0, 1'b1);
        for (int k = 0; k < 33; k++) send(-128, -128, 127, 127, 1'b0, k == 32);
        for (int k = 0; k < 4; k++) send(-128, 0, -128, -128, 1'b1, k == 3);
        in_valid = 1'b0;
      end
      collect(6, "saturation");
    join
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) send(k + 1, -k, 3 - k, 2 * k + 1, bit'(k % 2), 1'b1);
        in_valid = 1'b0;
      end
      begin
        int t = 0;
        longint er, ei;
        bit eo;
        @(negedge clk);
        while (!out_valid && t < 50) begin
          @(negedge clk);
          t++;
        end
        for (int c = 0; c < 5; c++) begin
          er = (sb.size() > 0) ? sb[0].r : 0;
          ei = (sb.size() > 0) ? sb[0].i : 0;
          eo = (sb.size() > 0) ? sb[0].ovf : 1'b0;
          checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || longint'(out_r) !== er ||
              longint'(out_i) !== ei || out_ovf !== eo) begin
            errors++;
            $display("FAIL bp_hold[%0d] in_ready=%0b valid=%0b out=%0d,%0d ovf=%0b expected 0,1,%0d,%0d,%0b",
                     c, in_ready, out_valid, out_r, out_i, out_ovf, er, ei, eo);
          end
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        collect(6, "bp_release");
      end
    join
    checks++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_no_dup out_valid=%0b expected 0", out_valid);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_frame();
    send(3, 1, 2, 2, 1'b0, 1'b0);
    send(-5, 4, 1, -1, 1'b0, 1'b0);
    in_valid = 1'b0;
    reset = 1'b0;
    m_r = 0;
    m_i = 0;
    m_ovf = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_r !== '0 || out_i !== '0 || out_ovf !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_clear valid=%0b out=%0d,%0d ovf=%0b in_ready=%0b expected 0,0,0,0,1",
               out_valid, out_r, out_i, out_ovf, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    fork
      begin
        send(2, 3, 4, 5, 1'b0, 1'b1);
        in_valid = 1'b0;
      end
      collect(1, "post_reset");
    join
    checks++;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_no_stale out_valid=%0b expected 0", out_valid);
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    conj_b = 1'b0;
    a_r = '0; a_i = '0; b_r = '0; b_i = '0;
    out_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_backpressure();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
